frame_scheduler: RTL and testbench

- Per-frame sequencer in the clk_render domain.
- Synchronises the pixel-domain frame pulse and decides when to swap the double framebuffer and start a new render pass.
- Waits until the render manager, triangle feeder and depth-buffer pipeline have fully drained, drops frames that arrive while work is still in flight, and steps the animation offsets.
- Also provides a watchdog and status counters.

---
 rtl/frame_scheduler_if.sv | 33 +++
 rtl/frame_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_frame_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - frame scheduler signal bundle
// Purpose: groups the frame pulse, busy inputs, frame-control pulses,
//          animation offsets and status outputs of frame_scheduler.
// Modports:
//   slave  - scheduler side: frame_pix/renderer_busy/feeder_busy in,
//            swap/begin_frame/offset_x/offset_y/frame_count/
//            dropped_count/timeout/state_dbg out
//   master - environment side, directions mirrored
interface frame_scheduler_if;
    logic               frame_pix;
    logic               renderer_busy;
    logic               feeder_busy;
    logic               swap;
    logic               begin_frame;
    logic signed [31:0] offset_x;
    logic signed [31:0] offset_y;
    logic [15:0]        frame_count;
    logic [15:0]        dropped_count;
    logic               timeout;
    logic [1:0]         state_dbg;

    modport slave (
        input  frame_pix, renderer_busy, feeder_busy,
        output swap, begin_frame, offset_x, offset_y,
               frame_count, dropped_count, timeout, state_dbg
    );

    modport master (
        output frame_pix, renderer_busy, feeder_busy,
        input  swap, begin_frame, offset_x, offset_y,
               frame_count, dropped_count, timeout, state_dbg
    );
endinterface

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame render sequencer
// Purpose: synchronises the pixel-domain frame pulse, starts a render pass
//          (swap + begin_frame) only when the pipeline is idle, waits for
//          busy to rise and fall plus a drain window, drops frames that
//          arrive while work is in flight, steps the animation offsets and
//          keeps a render watchdog and status counters.
// Ports:
//   clk_render - render clock
//   btn_rst_n  - asynchronous active-low reset (released synchronously)
//   sched      - frame_scheduler_if.slave bundle (see interface file)
module frame_scheduler #(
    parameter int unsigned        DRAIN_CYCLES   = 4,
    parameter int unsigned        ARM_TIMEOUT    = 16,
    parameter int unsigned        RENDER_TIMEOUT = 2000000,
    parameter logic signed [31:0] X_MIN          = -(160 << 15),
    parameter logic signed [31:0] X_MAX          = (160 << 15),
    parameter logic signed [31:0] X_STEP         = (1 << 15),
    parameter logic signed [31:0] Y_MIN          = 0,
    parameter logic signed [31:0] Y_MAX          = (120 << 15),
    parameter logic signed [31:0] Y_STEP         = (1 << 13)
) (
    input  logic             clk_render,
    input  logic             btn_rst_n,
    frame_scheduler_if.slave sched
);
    localparam int unsigned CNT_MAX0 = (ARM_TIMEOUT > DRAIN_CYCLES) ? ARM_TIMEOUT : DRAIN_CYCLES;
    localparam int unsigned CNT_MAX  = (RENDER_TIMEOUT > CNT_MAX0) ? RENDER_TIMEOUT : CNT_MAX0;
    localparam int          CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RENDER_LAST = CNT_W'(RENDER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        READY  = 2'd0,
        ARM    = 2'd1,
        RENDER = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Reset is asserted asynchronously but released on a clock edge.
    logic r_rst_meta, r_rst_sync;
    always_ff @(posedge clk_render or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    // Frame pulse synchroniser and edge detect. r_vld_cnt marks when
    // r_sync2_d holds a genuinely sampled value; edges are only honoured
    // once the synchronised pulse has been seen low, so a pulse already
    // high across reset release cannot start a frame.
    logic       r_sync1, r_sync2, r_sync2_d, r_edge_en;
    logic [1:0] r_vld_cnt;
    logic       w_frame_edge;
    always_ff @(posedge clk_render or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
            r_vld_cnt <= 2'd0;
            r_edge_en <= 1'b0;
        end else begin
            r_sync1   <= sched.frame_pix;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_vld_cnt <= (r_vld_cnt == 2'd3) ? 2'd3 : r_vld_cnt + 2'd1;
            r_edge_en <= r_edge_en | ((r_vld_cnt == 2'd3) & ~r_sync2_d);
        end
    end
    assign w_frame_edge = r_sync2 & ~r_sync2_d & r_edge_en;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             w_busy, w_start, w_drop, w_wd;

    assign w_busy = sched.renderer_busy | sched.feeder_busy;

    always_ff @(posedge clk_render or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state <= READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_start    = 1'b0;
        w_drop     = 1'b0;
        w_wd       = 1'b0;
        case (r_state)
            READY: begin
                if (w_frame_edge) begin
                    w_start    = 1'b1;
                    w_next     = ARM;
                    w_cnt_next = '0;
                end
            end
            ARM: begin
                w_drop = w_frame_edge;
                if (w_busy) begin
                    w_next     = RENDER;
                    w_cnt_next = '0;
                end else if (r_cnt == ARM_LAST) begin
                    // Nothing picked up the frame: treat it as empty.
                    w_next     = DRAIN;
                    w_cnt_next = DRAIN_LOAD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            RENDER: begin
                w_drop = w_frame_edge;
                if (!w_busy) begin
                    w_next     = DRAIN;
                    w_cnt_next = DRAIN_LOAD;
                end else if (r_cnt == RENDER_LAST) begin
                    w_wd       = 1'b1;
                    w_next     = DRAIN;
                    w_cnt_next = DRAIN_LOAD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                w_drop = w_frame_edge;
                if (w_busy) begin
                    w_cnt_next = DRAIN_LOAD;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_next = READY;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: w_next = READY;
        endcase
    end

    logic               r_swap, r_begin, r_timeout;
    logic signed [31:0] r_off_x, r_off_y;
    logic [15:0]        r_frame_count, r_dropped;
    always_ff @(posedge clk_render or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_swap        <= 1'b0;
            r_begin       <= 1'b0;
            r_timeout     <= 1'b0;
            r_off_x       <= X_MIN;
            r_off_y       <= Y_MIN;
            r_frame_count <= 16'd0;
            r_dropped     <= 16'd0;
        end else begin
            r_swap  <= w_start;
            r_begin <= w_start;
            if (w_start) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_off_x       <= (r_off_x >= X_MAX) ? X_MIN : r_off_x + X_STEP;
                r_off_y       <= (r_off_y >= Y_MAX) ? Y_MIN : r_off_y + Y_STEP;
            end
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
            if (w_wd) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign sched.swap          = r_swap;
    assign sched.begin_frame   = r_begin;
    assign sched.offset_x      = r_off_x;
    assign sched.offset_y      = r_off_y;
    assign sched.frame_count   = r_frame_count;
    assign sched.dropped_count = r_dropped;
    assign sched.timeout       = r_timeout;
    assign sched.state_dbg     = r_state;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler
module tb_frame_scheduler;
    localparam logic signed [31:0] X_MIN  = -(160 << 15);
    localparam logic signed [31:0] X_MAX  = (160 << 15);
    localparam logic signed [31:0] X_STEP = (1 << 15);
    localparam logic signed [31:0] Y_MIN  = 0;
    localparam logic signed [31:0] Y_MAX  = (120 << 15);
    localparam logic signed [31:0] Y_STEP = (1 << 13);
    localparam logic [1:0] S_READY = 2'd0, S_ARM = 2'd1, S_RENDER = 2'd2, S_DRAIN = 2'd3;

    typedef struct {
        logic [15:0]        fc;
        logic signed [31:0] x;
        logic signed [31:0] y;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    frame_scheduler_if bus ();

    frame_scheduler #(.RENDER_TIMEOUT(50)) dut (
        .clk_render (clk),
        .btn_rst_n  (rst_n),
        .sched      (bus)
    );

    int                 n_pass  = 0;
    int                 n_total = 0;
    exp_t               sb_q[$];
    logic [15:0]        exp_fc;
    logic [15:0]        exp_drop;
    logic signed [31:0] exp_x, exp_y;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 900000");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        exp_fc   = 16'd0;
        exp_drop = 16'd0;
        exp_x    = X_MIN;
        exp_y    = Y_MIN;
        sb_q.delete();
    endtask

    task automatic push_frame();
        exp_t e;
        exp_fc = exp_fc + 16'd1;
        exp_x  = (exp_x >= X_MAX) ? X_MIN : exp_x + X_STEP;
        exp_y  = (exp_y >= Y_MAX) ? Y_MIN : exp_y + Y_STEP;
        e.fc = exp_fc;
        e.x  = exp_x;
        e.y  = exp_y;
        sb_q.push_back(e);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int cycles);
        cycles = -1;
        for (int i = 0; i <= budget; i++) begin
            if (bus.state_dbg === s) begin
                cycles = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Drives a 3-cycle frame pulse and returns at the negedge where
    // begin_frame is seen (lat = negedges after the drive, -1 if never).
    task automatic start_frame(output int lat);
        push_frame();
        bus.frame_pix = 1'b1;
        lat = -1;
        for (int i = 1; i <= 6 && lat < 0; i++) begin
            @(negedge clk);
            if (i == 3) bus.frame_pix = 1'b0;
            if (bus.begin_frame === 1'b1) lat = i;
        end
        bus.frame_pix = 1'b0;
    endtask

    task automatic run_frame(output logic ok);
        int lat, c;
        start_frame(lat);
        wait_state(S_READY, 40, c);
        ok = (lat == 3) && (c >= 0);
    endtask

    task automatic monitor();
        exp_t e;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.swap === 1'b1 || bus.begin_frame === 1'b1) begin
                n_total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected_start: swap=%0b begin_frame=%0b, required no start", bus.swap, bus.begin_frame);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.swap !== 1'b1 || bus.begin_frame !== 1'b1 || prev !== 1'b0 ||
                        bus.frame_count !== e.fc || bus.offset_x !== e.x || bus.offset_y !== e.y)
                        $display("FAIL sb_frame: got swap=%0b begin=%0b prev=%0b fc=%0d x=%h y=%h, required swap=1 begin=1 prev=0 fc=%0d x=%h y=%h",
                                 bus.swap, bus.begin_frame, prev, bus.frame_count, bus.offset_x, bus.offset_y, e.fc, e.x, e.y);
                    else
                        n_pass++;
                end
            end
            prev = bus.swap | bus.begin_frame;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        n_total++;
        if (bus.state_dbg !== S_READY || bus.swap !== 1'b0 || bus.begin_frame !== 1'b0)
            $display("FAIL reset_ctrl: state=%0d swap=%0b begin=%0b, required 0 0 0", bus.state_dbg, bus.swap, bus.begin_frame);
        else n_pass++;
        n_total++;
        if (bus.offset_x !== 32'hFFB0_0000 || bus.offset_y !== 32'h0)
            $display("FAIL reset_offsets: x=%h y=%h, required ffb00000 00000000", bus.offset_x, bus.offset_y);
        else n_pass++;
        n_total++;
        if (bus.frame_count !== 16'd0 || bus.dropped_count !== 16'd0 || bus.timeout !== 1'b0)
            $display("FAIL reset_status: fc=%0d drop=%0d timeout=%0b, required 0 0 0", bus.frame_count, bus.dropped_count, bus.timeout);
        else n_pass++;
        rst_n = 1'b1;
        cyc(8);
        n_total++;
        if (bus.state_dbg !== S_READY || bus.frame_count !== 16'd0)
            $display("FAIL reset_release_idle: state=%0d fc=%0d, required 0 0", bus.state_dbg, bus.frame_count);
        else n_pass++;
    endtask

    task automatic test_first_frame();
        int swap_k = -1, n_swap = 0, n_arm = 0, n_drain = 0;
        logic [1:0] st_end = 2'd0;
        push_frame();
        bus.frame_pix = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 4) bus.frame_pix = 1'b0;
            if (bus.swap === 1'b1) begin
                n_swap++;
                swap_k = k;
            end
            if (bus.state_dbg === S_ARM) n_arm++;
            if (bus.state_dbg === S_DRAIN) n_drain++;
            if (k == 3) begin
                n_total++;
                if (bus.offset_x !== 32'hFFB0_8000 || bus.frame_count !== 16'd1)
                    $display("FAIL first_frame_values: x=%h fc=%0d, required ffb08000 1", bus.offset_x, bus.frame_count);
                else n_pass++;
            end
            st_end = bus.state_dbg;
        end
        n_total++;
        if (swap_k != 3 || n_swap != 1)
            $display("FAIL first_frame_latency: swap at edge %0d count %0d, required edge 3 count 1", swap_k, n_swap);
        else n_pass++;
        n_total++;
        if (n_arm != 16 || n_drain != 4 || st_end !== S_READY)
            $display("FAIL empty_frame_timing: arm=%0d drain=%0d end_state=%0d, required 16 4 0", n_arm, n_drain, st_end);
        else n_pass++;
    endtask

    task automatic test_render_drain();
        int lat;
        logic [1:0] st[1:5];
        start_frame(lat);
        cyc(2);
        bus.renderer_busy = 1'b1;
        cyc(3);
        n_total++;
        if (lat != 3 || bus.state_dbg !== S_RENDER)
            $display("FAIL render_entry: lat=%0d state=%0d, required 3 2", lat, bus.state_dbg);
        else n_pass++;
        cyc(25);
        bus.renderer_busy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            st[k] = bus.state_dbg;
        end
        n_total++;
        if (st[1] !== S_DRAIN || st[4] !== S_DRAIN || st[5] !== S_READY)
            $display("FAIL drain_window: states k1=%0d k4=%0d k5=%0d, required 3 3 0", st[1], st[4], st[5]);
        else n_pass++;
    endtask

    task automatic test_drain_reload();
        int lat;
        logic [1:0] st[1:7];
        start_frame(lat);
        bus.feeder_busy = 1'b1;
        cyc(3);
        n_total++;
        if (bus.state_dbg !== S_RENDER)
            $display("FAIL feeder_busy_render: state=%0d, required 2", bus.state_dbg);
        else n_pass++;
        cyc(5);
        bus.feeder_busy = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            st[k] = bus.state_dbg;
            bus.renderer_busy = (k == 2);
        end
        n_total++;
        if (st[3] !== S_DRAIN || st[6] !== S_DRAIN || st[7] !== S_READY)
            $display("FAIL drain_reload: states k3=%0d k6=%0d k7=%0d, required 3 3 0", st[3], st[6], st[7]);
        else n_pass++;
    endtask

    task automatic test_drop();
        int lat, c;
        start_frame(lat);
        bus.renderer_busy = 1'b1;
        cyc(4);
        bus.frame_pix = 1'b1;
        exp_drop = exp_drop + 16'd1;
        cyc(4);
        bus.frame_pix = 1'b0;
        cyc(4);
        n_total++;
        if (bus.dropped_count !== exp_drop || bus.frame_count !== exp_fc || bus.state_dbg !== S_RENDER)
            $display("FAIL drop_in_render: drop=%0d fc=%0d state=%0d, required %0d %0d 2",
                     bus.dropped_count, bus.frame_count, bus.state_dbg, exp_drop, exp_fc);
        else n_pass++;
        bus.renderer_busy = 1'b0;
        wait_state(S_READY, 20, c);
        start_frame(lat);
        n_total++;
        if (c < 0 || lat != 3 || bus.dropped_count !== exp_drop)
            $display("FAIL drop_then_start: ready_wait=%0d lat=%0d drop=%0d, required >=0 3 %0d", c, lat, bus.dropped_count, exp_drop);
        else n_pass++;
        wait_state(S_READY, 40, c);
    endtask

    task automatic test_offset_wrap();
        int bad = 0, guard = 0;
        logic ok;
        while (exp_x != X_MAX && guard < 1000) begin
            run_frame(ok);
            if (!ok) bad++;
            guard++;
        end
        n_total++;
        if (bus.offset_x !== 32'h0050_0000)
            $display("FAIL offset_x_max: x=%h, required 00500000", bus.offset_x);
        else n_pass++;
        run_frame(ok);
        if (!ok) bad++;
        n_total++;
        if (bus.offset_x !== 32'hFFB0_0000)
            $display("FAIL offset_x_wrap: x=%h, required ffb00000", bus.offset_x);
        else n_pass++;
        guard = 0;
        while (exp_y != Y_MAX && guard < 1000) begin
            run_frame(ok);
            if (!ok) bad++;
            guard++;
        end
        n_total++;
        if (bus.offset_y !== 32'h003C_0000)
            $display("FAIL offset_y_max: y=%h, required 003c0000", bus.offset_y);
        else n_pass++;
        run_frame(ok);
        if (!ok) bad++;
        n_total++;
        if (bus.offset_y !== 32'h0)
            $display("FAIL offset_y_wrap: y=%h, required 00000000", bus.offset_y);
        else n_pass++;
        n_total++;
        if (bad != 0)
            $display("FAIL back_to_back_frames: %0d frames late or stuck, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, c, rc = 0;
        logic ok;
        logic [1:0] st_exit = 2'd0;
        logic to_exit = 1'b0;
        n_total++;
        if (bus.timeout !== 1'b0)
            $display("FAIL timeout_initial: timeout=%0b, required 0", bus.timeout);
        else n_pass++;
        start_frame(lat);
        bus.renderer_busy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.state_dbg === S_RENDER) rc++;
            else if (rc > 0) begin
                st_exit = bus.state_dbg;
                to_exit = bus.timeout;
                break;
            end
        end
        n_total++;
        if (rc != 50 || st_exit !== S_DRAIN || to_exit !== 1'b1)
            $display("FAIL watchdog_fire: render_cycles=%0d state=%0d timeout=%0b, required 50 3 1", rc, st_exit, to_exit);
        else n_pass++;
        cyc(10);
        n_total++;
        if (bus.state_dbg !== S_DRAIN)
            $display("FAIL drain_hold_busy: state=%0d, required 3", bus.state_dbg);
        else n_pass++;
        bus.renderer_busy = 1'b0;
        wait_state(S_READY, 20, c);
        run_frame(ok);
        n_total++;
        if (c < 0 || !ok || bus.timeout !== 1'b1)
            $display("FAIL timeout_sticky: ready_wait=%0d frame_ok=%0b timeout=%0b, required >=0 1 1", c, ok, bus.timeout);
        else n_pass++;
        rst_n = 1'b0;
        model_reset();
        cyc(1);
        n_total++;
        if (bus.timeout !== 1'b0)
            $display("FAIL timeout_cleared: timeout=%0b, required 0", bus.timeout);
        else n_pass++;
        rst_n = 1'b1;
        cyc(8);
    endtask

    task automatic test_reset_mid_render();
        int lat, n_begin = 0;
        start_frame(lat);
        bus.renderer_busy = 1'b1;
        cyc(4);
        bus.frame_pix = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.state_dbg !== S_READY || bus.swap !== 1'b0 || bus.begin_frame !== 1'b0 ||
            bus.frame_count !== 16'd0 || bus.dropped_count !== 16'd0 ||
            bus.offset_x !== 32'hFFB0_0000 || bus.offset_y !== 32'h0 || bus.timeout !== 1'b0)
            $display("FAIL reset_async: state=%0d swap=%0b begin=%0b fc=%0d drop=%0d x=%h y=%h to=%0b, required 0 0 0 0 0 ffb00000 00000000 0",
                     bus.state_dbg, bus.swap, bus.begin_frame, bus.frame_count, bus.dropped_count,
                     bus.offset_x, bus.offset_y, bus.timeout);
        else n_pass++;
        model_reset();
        bus.renderer_busy = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.begin_frame === 1'b1) n_begin++;
        end
        n_total++;
        if (n_begin != 0)
            $display("FAIL held_pulse_ignored: begin_frame seen %0d times, required 0", n_begin);
        else n_pass++;
        bus.frame_pix = 1'b0;
        cyc(4);
        start_frame(lat);
        n_total++;
        if (lat != 3 || bus.frame_count !== 16'd1)
            $display("FAIL restart_after_fall: lat=%0d fc=%0d, required 3 1", lat, bus.frame_count);
        else n_pass++;
        cyc(30);
    endtask

    initial begin
        bus.frame_pix     = 1'b0;
        bus.renderer_busy = 1'b0;
        bus.feeder_busy   = 1'b0;
        model_reset();
        fork
            monitor();
        join_none
        test_reset();
        test_first_frame();
        test_render_drain();
        test_drain_reload();
        test_drop();
        test_offset_wrap();
        test_timeout();
        test_reset_mid_render();
        n_total++;
        if (sb_q.size() != 0)
            $display("FAIL sb_leftover: %0d expected frames never started, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
